// File: rtl/gray_seq_pkg.sv
// gray_seq_pkg: shared FSM state, run-mode and direction encodings for the Gray sequencer
package gray_seq_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_FREE    = 1'b1;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/gray_seq_ctrl_if.sv
// gray_seq_ctrl_if: command/status bundle between a command source and the Gray sequencer
// master (command source) drives: start, mode, dir, len, pause, stop, clr
// slave  (sequencer)      drives: gray, busy, done, wrap
interface gray_seq_ctrl_if #(parameter int N = 4) ();
  logic         start;
  logic         mode;
  logic         dir;
  logic [N-1:0] len;
  logic         pause;
  logic         stop;
  logic         clr;
  logic [N-1:0] gray;
  logic         busy;
  logic         done;
  logic         wrap;
  modport master (output start, mode, dir, len, pause, stop, clr, input gray, busy, done, wrap);
  modport slave  (input start, mode, dir, len, pause, stop, clr, output gray, busy, done, wrap);
endinterface

// File: rtl/gray_step_core.sv
// gray_step_core: N-bit binary counter with +/-1 step, clear, registered Gray output and wrap pulse
// ports: clk, reset_n (async active-low), en_i (step), dir_i (1 = down), clr_i (zero count),
//        gray_o (registered Gray code), wrap_o (pulse after a step crossing max<->0)
module gray_step_core import gray_seq_pkg::*; #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic         dir_i,
  input  logic         clr_i,
  output logic [N-1:0] gray_o,
  output logic         wrap_o
);
  logic [N-1:0] bin_q, bin_d, gray_q;
  logic         wrap_q, wrap_d;
  always_comb begin
    bin_d  = clr_i ? '0 : en_i ? (dir_i == DIR_DOWN ? bin_q - 1'b1 : bin_q + 1'b1) : bin_q;
    wrap_d = en_i && !clr_i && (dir_i == DIR_DOWN ? bin_q == '0 : &bin_q);
  end
  // Gray is computed from the next binary value so a step shows on gray at the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= bin_d ^ (bin_d >> 1);
      wrap_q <= wrap_d;
    end
  end
  assign gray_o = gray_q;
  assign wrap_o = wrap_q;
endmodule

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: IDLE/RUN/DONE sequencer stepping a Gray counter in one-shot or free-run mode
// ports: clk, reset_n (async active-low), bus (slave side of gray_seq_ctrl_if: commands in,
//        gray/busy/done/wrap status out)
module gray_seq_ctrl import gray_seq_pkg::*; #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  gray_seq_ctrl_if.slave bus
);
  logic [1:0]   state_q, state_d;
  logic         mode_q, mode_d, dir_q, dir_d, step;
  logic [N-1:0] len_q, len_d, cnt_q, cnt_d;
  // RUN priority: stop > pause > step; a one-shot finishes on the step reaching len.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        mode_d  = bus.mode;
        dir_d   = bus.dir;
        len_d   = bus.len;
        cnt_d   = '0;
        state_d = (bus.mode == MODE_FREE || bus.len != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: if (bus.stop) state_d = ST_IDLE;
      else if (!bus.pause) begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (mode_q == MODE_ONESHOT && cnt_d == len_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ONESHOT;
      dir_q   <= DIR_UP;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end
  gray_step_core #(.N(N)) u_core (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (step),
    .dir_i  (dir_q),
    .clr_i  (state_q == ST_IDLE && bus.clr),
    .gray_o (bus.gray),
    .wrap_o (bus.wrap)
  );
  assign bus.busy = state_q == ST_RUN;
  assign bus.done = state_q == ST_DONE;
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: scoreboard bench for gray_seq_ctrl (N=4)
module tb_gray_seq_ctrl;
  typedef struct {logic [3:0] gray; logic busy; logic done; logic wrap;} exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  string cur = "reset";
  exp_t sb[$];
  logic [3:0] prev;
  gray_seq_ctrl_if #(.N(4)) bus ();
  gray_seq_ctrl #(.N(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [3:0] gc(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", cur, tag, act, exp);
    end
  endtask
  task automatic step_chk(input logic [3:0] g, input logic b, input logic d, input logic w);
    exp_t e;
    sb.push_back('{g, b, d, w});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gray", bus.gray, e.gray);
    chk("busy", bus.busy, e.busy);
    chk("done", bus.done, e.done);
    chk("wrap", bus.wrap, e.wrap);
  endtask
  task automatic cmd(input logic m, input logic d, input logic [3:0] l);
    bus.start = 1'b1;
    bus.mode = m;
    bus.dir = d;
    bus.len = l;
  endtask
  initial begin
    bus.start = 0; bus.mode = 0; bus.dir = 0; bus.len = 0;
    bus.pause = 0; bus.stop = 0; bus.clr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("gray", bus.gray, 0);
    chk("busy", bus.busy, 0);
    chk("done", bus.done, 0);
    chk("wrap", bus.wrap, 0);
    reset_n = 1'b1;
    cur = "oneshot_up5";
    cmd(0, 0, 5);
    step_chk(gc(0), 1, 0, 0);
    bus.start = 0;
    for (int i = 1; i <= 5; i++) step_chk(gc(i), i < 5, i == 5, 0);
    step_chk(gc(5), 0, 0, 0);
    step_chk(gc(5), 0, 0, 0);
    cur = "free_up16";
    bus.clr = 1;
    step_chk(0, 0, 0, 0);
    bus.clr = 0;
    cmd(1, 0, 0);
    step_chk(0, 1, 0, 0);
    bus.start = 0;
    prev = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      step_chk(gc(i), 1, 0, i == 16);
      chk("hamming", $countones(bus.gray ^ prev), 1);
      prev = bus.gray;
    end
    bus.stop = 1;
    step_chk(gc(0), 0, 0, 0);
    bus.stop = 0;
    cur = "oneshot_down1_clr";
    bus.clr = 1;
    cmd(0, 1, 1);
    step_chk(0, 1, 0, 0);
    bus.clr = 0;
    bus.start = 0;
    step_chk(4'b1000, 0, 1, 1);
    step_chk(4'b1000, 0, 0, 0);
    cur = "pause3";
    bus.clr = 1;
    cmd(0, 0, 4);
    step_chk(0, 1, 0, 0);
    bus.clr = 0;
    bus.start = 0;
    step_chk(gc(1), 1, 0, 0);
    step_chk(gc(2), 1, 0, 0);
    bus.pause = 1;
    repeat (3) step_chk(gc(2), 1, 0, 0);
    bus.pause = 0;
    step_chk(gc(3), 1, 0, 0);
    step_chk(gc(4), 0, 1, 0);
    step_chk(gc(4), 0, 0, 0);
    cur = "stop_pause";
    cmd(1, 0, 0);
    step_chk(gc(4), 1, 0, 0);
    bus.start = 0;
    step_chk(gc(5), 1, 0, 0);
    bus.stop = 1;
    bus.pause = 1;
    step_chk(gc(5), 0, 0, 0);
    bus.stop = 0;
    bus.pause = 0;
    step_chk(gc(5), 0, 0, 0);
    cur = "len0";
    cmd(0, 0, 0);
    step_chk(gc(5), 0, 1, 0);
    bus.start = 0;
    step_chk(gc(5), 0, 0, 0);
    cur = "start_in_done";
    cmd(0, 0, 0);
    step_chk(gc(5), 0, 1, 0);
    cmd(0, 0, 3);
    step_chk(gc(5), 0, 0, 0);
    bus.start = 0;
    step_chk(gc(5), 0, 0, 0);
    cur = "stop_final";
    cmd(0, 0, 2);
    step_chk(gc(5), 1, 0, 0);
    bus.start = 0;
    step_chk(gc(6), 1, 0, 0);
    bus.stop = 1;
    step_chk(gc(6), 0, 0, 0);
    bus.stop = 0;
    step_chk(gc(6), 0, 0, 0);
    cur = "async_reset";
    cmd(1, 0, 0);
    step_chk(gc(6), 1, 0, 0);
    bus.start = 0;
    step_chk(gc(7), 1, 0, 0);
    step_chk(gc(8), 1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("gray", bus.gray, 0);
    chk("busy", bus.busy, 0);
    chk("done", bus.done, 0);
    chk("wrap", bus.wrap, 0);
    #1;
    reset_n = 1'b1;
    step_chk(0, 0, 0, 0);
    step_chk(0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_seq_ctrl.md
# gray_seq_ctrl

Sequencer for an N-bit Gray-code counter. It accepts a start command with a run mode, step count and direction. It then steps the counter one code per cycle until the count is exhausted or software stops it, and reports completion and wrap events. It sits between a command source (CPU register block or test sequencer) and the Gray counter datapath it owns.

## Interface
Parameters:
- N, 4, counter width in bits (2..16).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; accepted only in IDLE.
- mode  in  1  0 = one-shot (run len steps), 1 = free-run; latched on accepted start.
- dir  in  1  0 = up, 1 = down; latched on accepted start.
- len  in  N  step count for one-shot; latched on accepted start.
- pause  in  1  in RUN: hold, no step this cycle.
- stop  in  1  in RUN: abort to IDLE.
- clr  in  1  in IDLE: zero the counter; ignored elsewhere.
- gray  out  N  registered Gray code of internal binary count.
- busy  out  1  high in RUN.
- done  out  1  high for exactly one cycle (state DONE) after a one-shot completes.
- wrap  out  1  one-cycle registered pulse in the cycle after a step that crossed 2^N-1→0 (up) or 0→2^N-1 (down).

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, binary count 0, gray 0, busy 0, done 0, wrap 0, step counter 0.
- IDLE:
  - start=1 → latch mode/dir/len, clear step counter.
  - Next state: RUN if mode=1 or len≠0; DONE if mode=0 and len=0 (zero steps, done still pulses).
  - clr=1 with start=1: counter cleared and start accepted in the same edge.
- RUN, per edge, priority stop > pause > step:
  - stop=1 → IDLE, no step, no done.
  - pause=1 → no change.
  - Otherwise the binary count steps ±1 modulo 2^N and the step counter increments.
  - One-shot: the step that makes the step counter equal len also moves the state to DONE.
  - Free-run: never leaves RUN except on stop.
- DONE → IDLE unconditionally next edge. start in DONE is ignored.
- Arithmetic:
  - Binary count is N bits and wraps silently.
  - gray = bin ^ (bin >> 1), registered.
  - Consecutive gray values always differ in exactly one bit.
  - Step counter is N bits wide; len max is 2^N-1.
- Counter value is retained across IDLE; only clr or reset zeroes it.
- start, pause and stop outside their valid states have no effect.
- Reset assertion mid-operation: immediate return to reset values, no done.

## Timing
- start accepted at edge k → busy=1 from edge k.
- First step at edge k+1 if pause=0 at that edge.
- One-shot, len=L, no pause:
  - Steps at edges k+1..k+L.
  - done=1 from edge k+L to edge k+L+1, busy=0 from edge k+L.
- Each pause cycle delays completion by exactly one cycle.
- gray reflects a step at the same edge (zero added latency). wrap is high in the cycle following the wrapping edge.
- stop sampled at edge j: gray holds its edge-(j-1) value; busy=0 from edge j.
- stop on the final one-shot step edge: stop wins; no step, no done.

## Structure
- Shared package/defines file gray_seq_pkg holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2),
  - mode constants (MODE_ONESHOT=0, MODE_FREE=1),
  - direction constants.
- One sub-module, gray_step_core. It holds the binary register, the ±1 step with enable/dir/clr, the bin→gray conversion and wrap detect.
- The controller holds the FSM, latched command fields and the step counter.

## Test plan
- Reset then one-shot up, len=5 from 0 → gray sequence 0001,0011,0010,0110,0111; done pulses once; busy low after; gray stays 0111.
- Free-run up from 0 for 16 steps → wrap pulses once, after 1000→0000; every transition has Hamming distance 1.
- One-shot down, len=1 from 0 after clr → gray=1000 (bin 15); wrap=1 next cycle; done=1.
- One-shot len=4 with pause held 3 cycles mid-run → gray frozen during pause; done arrives 3 cycles later than the unpaused run.
- stop and pause both high in RUN → returns to IDLE, gray unchanged, no done. start with len=0 → done pulses, gray unchanged.
- reset_n pulsed low mid-run (asynchronously, between edges) → gray=0000, busy=0, done=0 immediately. start during DONE is ignored.
